// File: rtl/alu_issue_controller.sv
// -----------------------------------------------------------------------------
// alu_issue_controller
//
// Sequences a shared BITS-wide ALU datapath one operation at a time.
// A request is accepted over a valid/ready channel, its operands/opcode/carry
// are registered onto the ALU inputs, the controller waits an op-dependent
// number of cycles (ALU_LAT, or MUL_LAT for MUL), then captures result and
// flags and presents them on a valid/ready response channel. It also owns the
// architectural NZCV register ({V,C,Z,N} = [3:0]).
//
// Opcodes: ADD=00, SUB=01, MUL=10, PASS_B=11.
//
// Ports:
//   CLK, RST_N            clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY   request handshake
//   REQ_OP/A/B            opcode and operands
//   REQ_SETF              update NZCV from this op
//   REQ_USEC              use stored C flag as carry-in
//   ALU_A/B/OP/CIN        registered ALU inputs
//   ALU_RST/ALU_FLAGS     ALU result and flags
//   RSP_VALID/RSP_READY   response handshake
//   RSP_DATA/RSP_FLAGS    captured result and flags
//   NZCV_Q                architectural flag register
//
// Optional feature: define ALU_SEQ_BACK2BACK_EN to let a response handshake
// and a new request accept happen on the same edge (DONE -> EXEC directly).
// -----------------------------------------------------------------------------
module alu_issue_controller #(
  parameter int BITS    = 24,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [1:0]      REQ_OP,
  input  logic [BITS-1:0] REQ_A,
  input  logic [BITS-1:0] REQ_B,
  input  logic            REQ_SETF,
  input  logic            REQ_USEC,
  output logic [BITS-1:0] ALU_A,
  output logic [BITS-1:0] ALU_B,
  output logic [1:0]      ALU_OP,
  output logic            ALU_CIN,
  input  logic [BITS-1:0] ALU_RST,
  input  logic [3:0]      ALU_FLAGS,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [BITS-1:0] RSP_DATA,
  output logic [3:0]      RSP_FLAGS,
  output logic [3:0]      NZCV_Q
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_MUL    = 2'b10;
  localparam logic [1:0] OP_PASS_B = 2'b11;

  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] ALU_LOAD = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  state_e            state_q, state_d;
  logic [BITS-1:0]   alu_a_q, alu_a_d;
  logic [BITS-1:0]   alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              alu_cin_q, alu_cin_d;
  logic              setf_q, setf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0]   rsp_data_q, rsp_data_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic [3:0]        nzcv_q, nzcv_d;

  logic              req_ready;
  logic              accept;

  // Ready is combinational so a request can be taken the same cycle.
`ifdef ALU_SEQ_BACK2BACK_EN
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && RSP_READY);
`else
  assign req_ready = (state_q == ST_IDLE);
`endif

  assign accept = REQ_VALID && req_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_cin_d   = alu_cin_q;
    setf_d      = setf_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    nzcv_d      = nzcv_q;

    case (state_q)
      ST_IDLE: ; // accept handled below
      ST_EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d  = ALU_RST;
          rsp_flags_d = ALU_FLAGS;
          rsp_valid_d = 1'b1;
          // PASS_B is a data move and never touches the architectural flags.
          if (setf_q && (alu_op_q != OP_PASS_B)) nzcv_d = ALU_FLAGS;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // accept is only possible in IDLE, or in DONE during the response
    // handshake when back-to-back issue is enabled; it overrides the above.
    // The carry source is NZCV as registered before this edge.
    if (accept) begin
      alu_a_d   = REQ_A;
      alu_b_d   = REQ_B;
      alu_op_d  = REQ_OP;
      alu_cin_d = REQ_USEC ? nzcv_q[2] : 1'b0;
      setf_d    = REQ_SETF;
      cnt_d     = (REQ_OP == OP_MUL) ? MUL_LOAD : ALU_LOAD;
      state_d   = ST_EXEC;
    end
  end

  // NOTE: every register, including the datapath ones, is reset so the ALU
  // sees defined inputs (PASS_B of zero) straight out of reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_PASS_B;
      alu_cin_q   <= 1'b0;
      setf_q      <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      nzcv_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_cin_q   <= alu_cin_d;
      setf_q      <= setf_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      nzcv_q      <= nzcv_d;
    end
  end

  assign REQ_READY = req_ready;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_OP    = alu_op_q;
  assign ALU_CIN   = alu_cin_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_FLAGS = rsp_flags_q;
  assign NZCV_Q    = nzcv_q;

endmodule

// File: tb/tb_alu_issue_controller.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_controller
//
// Self-checking bench for alu_issue_controller (BITS=24, ALU_LAT=1,
// MUL_LAT=3). A behavioural ALU drives ALU_RST/ALU_FLAGS from the DUT's
// registered ALU inputs. Expected responses are computed when a request is
// driven and pushed to a scoreboard queue, then popped when the DUT responds.
// -----------------------------------------------------------------------------
module tb_alu_issue_controller;

  localparam int BITS    = 24;
  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 3;

  typedef struct packed {
    logic [BITS-1:0] data;
    logic [3:0]      flags;
    logic [3:0]      nzcv;
    int unsigned     lat;
  } exp_t;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            REQ_VALID;
  logic            REQ_READY;
  logic [1:0]      REQ_OP;
  logic [BITS-1:0] REQ_A;
  logic [BITS-1:0] REQ_B;
  logic            REQ_SETF;
  logic            REQ_USEC;
  logic [BITS-1:0] ALU_A;
  logic [BITS-1:0] ALU_B;
  logic [1:0]      ALU_OP;
  logic            ALU_CIN;
  logic [BITS-1:0] ALU_RST;
  logic [3:0]      ALU_FLAGS;
  logic            RSP_VALID;
  logic            RSP_READY;
  logic [BITS-1:0] RSP_DATA;
  logic [3:0]      RSP_FLAGS;
  logic [3:0]      NZCV_Q;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic [3:0] exp_nzcv = 4'h0;
  logic       exp_cin;

  always #5 CLK = ~CLK;

  alu_issue_controller #(
    .BITS(BITS), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_SETF(REQ_SETF), .REQ_USEC(REQ_USEC),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_CIN(ALU_CIN),
    .ALU_RST(ALU_RST), .ALU_FLAGS(ALU_FLAGS),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_DATA(RSP_DATA), .RSP_FLAGS(RSP_FLAGS), .NZCV_Q(NZCV_Q)
  );

  // Reference ALU: returns {flags{V,C,Z,N}, result}. SUB computes a-b-cin
  // with C as the borrow out; MUL and PASS_B clear C and V.
  function automatic logic [BITS+3:0] alu_model(input logic [1:0] op,
                                                 input logic [BITS-1:0] a,
                                                 input logic [BITS-1:0] b,
                                                 input logic cin);
    logic [BITS:0]     wide;
    logic [2*BITS-1:0] prod;
    logic [BITS-1:0]   r;
    logic              c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      2'b00: begin
        wide = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, cin};
        r = wide[BITS-1:0]; c = wide[BITS];
        v = (a[BITS-1] == b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
      end
      2'b01: begin
        wide = {1'b0, a} - {1'b0, b} - {{BITS{1'b0}}, cin};
        r = wide[BITS-1:0]; c = wide[BITS];
        v = (a[BITS-1] != b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
      end
      2'b10: begin
        prod = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
        r = prod[BITS-1:0];
      end
      default: r = b;
    endcase
    return {v, c, (r == '0), r[BITS-1], r};
  endfunction

  always_comb {ALU_FLAGS, ALU_RST} = alu_model(ALU_OP, ALU_A, ALU_B, ALU_CIN);

  // Drive one request (called #1 after a rising edge), push its expectation
  // and return once the accept edge has passed (#1 after it).
  task automatic issue(input logic [1:0] op, input logic [BITS-1:0] a,
                       input logic [BITS-1:0] b, input logic setf,
                       input logic usec, output bit ok);
    exp_t e;
    logic [BITS+3:0] m;
    bit rdy;
    exp_cin = usec ? exp_nzcv[2] : 1'b0;
    m = alu_model(op, a, b, exp_cin);
    if (setf && op != 2'b11) exp_nzcv = m[BITS+3:BITS];
    e.data  = m[BITS-1:0];
    e.flags = m[BITS+3:BITS];
    e.nzcv  = exp_nzcv;
    e.lat   = (op == 2'b10) ? MUL_LAT : ALU_LAT;
    sb_q.push_back(e);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_A = a; REQ_B = b;
    REQ_SETF = setf; REQ_USEC = usec;
    rdy = 1'b0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge CLK);
      rdy = REQ_READY;
      @(posedge CLK);
    end
    #1;
    REQ_VALID = 1'b0;
    ok = rdy;
  endtask

  // Waits for RSP_VALID, sampling #1 after each rising edge; lat counts edges.
  task automatic wait_rsp(output int lat, output bit ok);
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (RSP_VALID === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_OP = 2'b00; REQ_A = '0; REQ_B = '0;
    REQ_SETF = 1'b0; REQ_USEC = 1'b0; RSP_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    n_cmp++; if (REQ_READY !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", REQ_READY); end
    n_cmp++; if (RSP_VALID !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID); end
    n_cmp++; if (NZCV_Q !== 4'h0) begin n_err++; $display("FAIL reset_nzcv: got %h want 0", NZCV_Q); end
    n_cmp++; if (ALU_OP !== 2'b11) begin n_err++; $display("FAIL reset_alu_op: got %b want 11", ALU_OP); end
    n_cmp++; if ({ALU_A, ALU_B, ALU_CIN, RSP_DATA, RSP_FLAGS} !== '0) begin
      n_err++; $display("FAIL reset_regs: a=%h b=%h cin=%b data=%h flags=%h want all 0",
                        ALU_A, ALU_B, ALU_CIN, RSP_DATA, RSP_FLAGS);
    end
  endtask

  // Pop the scoreboard and compare one completed response, then handshake.
  task automatic test_add();
    bit ok; int lat; exp_t e;
    issue(2'b00, 24'h000005, 24'h000003, 1'b1, 1'b0, ok);
    wait_rsp(lat, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok || lat != int'(e.lat)) begin n_err++; $display("FAIL add_latency: got %0d (seen=%0b) want %0d", lat, ok, e.lat); end
    n_cmp++; if (RSP_DATA !== 24'h000008 || RSP_DATA !== e.data) begin n_err++; $display("FAIL add_data: got %h want 000008", RSP_DATA); end
    n_cmp++; if (NZCV_Q !== 4'b0000) begin n_err++; $display("FAIL add_nzcv: got %b want 0000", NZCV_Q); end
    @(posedge CLK); #1;
    n_cmp++; if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
      n_err++; $display("FAIL add_handshake: rsp_valid=%b req_ready=%b want 0/1", RSP_VALID, REQ_READY);
    end
  endtask

  task automatic test_sub_pass();
    bit ok; int lat; exp_t e;
    issue(2'b01, 24'h000003, 24'h000003, 1'b1, 1'b0, ok);
    wait_rsp(lat, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok || RSP_DATA !== e.data || NZCV_Q[1] !== 1'b1 || NZCV_Q !== e.nzcv) begin
      n_err++; $display("FAIL sub_zero: data=%h nzcv=%b want data=%h nzcv=%b", RSP_DATA, NZCV_Q, e.data, e.nzcv);
    end
    @(posedge CLK); #1;
    issue(2'b11, 24'h000000, 24'h800000, 1'b1, 1'b0, ok);
    wait_rsp(lat, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok || RSP_DATA !== 24'h800000) begin n_err++; $display("FAIL pass_data: got %h want 800000", RSP_DATA); end
    n_cmp++; if (RSP_FLAGS[0] !== 1'b1 || RSP_FLAGS !== e.flags) begin n_err++; $display("FAIL pass_flags: got %b want %b", RSP_FLAGS, e.flags); end
    n_cmp++; if (NZCV_Q !== 4'b0010) begin n_err++; $display("FAIL pass_nzcv_kept: got %b want 0010", NZCV_Q); end
    @(posedge CLK); #1;
  endtask

  task automatic test_mul();
    bit ok; int lat; exp_t e; bit again;
    issue(2'b10, 24'h000010, 24'h000020, 1'b0, 1'b0, ok);
    // Pulse a different request during EXEC; it must not be taken.
    REQ_VALID = 1'b1; REQ_OP = 2'b00; REQ_A = 24'h0000AA; REQ_B = 24'h000001;
    @(negedge CLK);
    n_cmp++; if (REQ_READY !== 1'b0) begin n_err++; $display("FAIL mul_busy_ready: got %b want 0", REQ_READY); end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    wait_rsp(lat, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok || lat + 1 != MUL_LAT) begin n_err++; $display("FAIL mul_latency: got %0d want %0d", lat + 1, MUL_LAT); end
    n_cmp++; if (RSP_DATA !== 24'h000200 || RSP_DATA !== e.data) begin n_err++; $display("FAIL mul_data: got %h want 000200", RSP_DATA); end
    n_cmp++; if (ALU_A !== 24'h000010) begin n_err++; $display("FAIL mul_operand_held: got %h want 000010", ALU_A); end
    again = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (RSP_VALID === 1'b1) again = 1'b1;
    end
    n_cmp++; if (again) begin n_err++; $display("FAIL mul_pulse_ignored: got a second response want none"); end
  endtask

  task automatic test_carry_chain();
    bit ok; int lat; exp_t e;
    issue(2'b00, 24'hFFFFFF, 24'h000001, 1'b1, 1'b0, ok);
    wait_rsp(lat, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok || RSP_DATA !== 24'h000000 || NZCV_Q !== 4'b0110) begin
      n_err++; $display("FAIL carry_set: data=%h nzcv=%b want 000000/0110", RSP_DATA, NZCV_Q);
    end
    @(posedge CLK); #1;
    issue(2'b00, 24'h000000, 24'h000000, 1'b0, 1'b1, ok);
    n_cmp++; if (ALU_CIN !== 1'b1 || ALU_CIN !== exp_cin) begin n_err++; $display("FAIL carry_cin: got %b want 1", ALU_CIN); end
    wait_rsp(lat, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok || RSP_DATA !== 24'h000001 || RSP_DATA !== e.data) begin n_err++; $display("FAIL carry_data: got %h want 000001", RSP_DATA); end
    n_cmp++; if (NZCV_Q !== 4'b0110) begin n_err++; $display("FAIL carry_nzcv_kept: got %b want 0110", NZCV_Q); end
    @(posedge CLK); #1;
  endtask

  task automatic test_stall_reset();
    bit ok; int lat; exp_t e; bit moved;
    RSP_READY = 1'b0;
    issue(2'b00, 24'h123456, 24'h111111, 1'b1, 1'b0, ok);
    wait_rsp(lat, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok || RSP_DATA !== e.data || RSP_DATA !== 24'h234567) begin n_err++; $display("FAIL stall_data: got %h want 234567", RSP_DATA); end
    moved = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (RSP_VALID !== 1'b1 || RSP_DATA !== e.data || RSP_FLAGS !== e.flags) moved = 1'b1;
    end
    n_cmp++; if (moved) begin n_err++; $display("FAIL stall_hold: got data=%h valid=%b want %h/1", RSP_DATA, RSP_VALID, e.data); end
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    exp_nzcv = 4'h0;
    sb_q.delete();
    RSP_READY = 1'b1;
    @(negedge CLK);
    n_cmp++; if (RSP_VALID !== 1'b0 || NZCV_Q !== 4'h0 || REQ_READY !== 1'b1) begin
      n_err++; $display("FAIL stall_reset: valid=%b nzcv=%b ready=%b want 0/0000/1", RSP_VALID, NZCV_Q, REQ_READY);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; exp_t e;
    logic [1:0] op;
    for (int n = 0; n < 10; n++) begin
      op = 2'($urandom_range(0, 3));
      issue(op, 24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ok);
      n_cmp++; if (!ok || ALU_CIN !== exp_cin) begin n_err++; $display("FAIL b2b_cin[%0d]: got %b want %b", n, ALU_CIN, exp_cin); end
      wait_rsp(lat, ok);
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL b2b_scoreboard[%0d]: got empty queue want an entry", n);
      end else begin
        e = sb_q.pop_front();
        n_cmp++; if (!ok || lat != int'(e.lat) || RSP_DATA !== e.data || RSP_FLAGS !== e.flags || NZCV_Q !== e.nzcv) begin
          n_err++; $display("FAIL b2b_rsp[%0d] op=%0d: got lat=%0d data=%h flags=%b nzcv=%b want %0d/%h/%b/%b",
                            n, op, lat, RSP_DATA, RSP_FLAGS, NZCV_Q, e.lat, e.data, e.flags, e.nzcv);
        end
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_pass();
    test_mul();
    test_carry_chain();
    test_stall_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_controller.md
Name: alu_issue_controller

Overview:
- Sequences the shared N-bit ALU datapath (ADD=00, SUB=01, MUL=10, PASS_B=11).
- Accepts one operation at a time over a valid/ready request channel and drives the ALU operand/opcode/carry inputs from registers.
- Waits an op-dependent number of cycles, then captures result and flags and presents them on a valid/ready response channel.
- Owns the architectural NZCV register that conditional logic downstream reads.

Parameters:
BITS, 24, datapath width; must match the ALU instance.
ALU_LAT, 1, cycles allowed for ADD/SUB/PASS_B to settle (>=1).
MUL_LAT, 3, cycles allowed for MUL to settle (>=1).

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
REQ_VALID  in  1  request present.
REQ_READY  out  1  controller can accept a request.
REQ_OP  in  2  ALU opcode.
REQ_A  in  BITS  operand A.
REQ_B  in  BITS  operand B.
REQ_SETF  in  1  update NZCV from this op.
REQ_USEC  in  1  use stored C flag as carry-in.
ALU_A  out  BITS  registered operand A to ALU.
ALU_B  out  BITS  registered operand B to ALU.
ALU_OP  out  2  registered opcode to ALU.
ALU_CIN  out  1  registered carry-in to ALU.
ALU_RST  in  BITS  ALU result.
ALU_FLAGS  in  4  ALU flags {V,C,Z,N} = [3:0].
RSP_VALID  out  1  response present.
RSP_READY  in  1  consumer accepts response.
RSP_DATA  out  BITS  captured result.
RSP_FLAGS  out  4  captured ALU flags for this op, always captured regardless of REQ_SETF.
NZCV_Q  out  4  architectural flag register, same bit order as ALU_FLAGS.

Behaviour:
- States: IDLE, EXEC, DONE.
- Reset (async, RST_N=0):
  - State=IDLE; REQ_READY=1 after release.
  - RSP_VALID=0; RSP_DATA=0; RSP_FLAGS=0; NZCV_Q=0.
  - ALU_A=0, ALU_B=0, ALU_CIN=0.
  - ALU_OP=2'b11 (PASS_B, a harmless idle op).
  - Wait counter=0.
  - Reset mid-EXEC or mid-DONE discards the op; no flag update occurs.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY at edge k: latch REQ_A/REQ_B/REQ_OP into ALU_A/ALU_B/ALU_OP.
  - Same edge: latch REQ_SETF; set ALU_CIN = REQ_USEC ? NZCV_Q[2] : 0.
  - Same edge: load counter with (REQ_OP==2'b10 ? MUL_LAT : ALU_LAT) - 1; go EXEC.
- EXEC:
  - REQ_READY=0; ALU inputs held stable.
  - Counter decrements each cycle.
  - On the edge where counter==0:
    - Capture ALU_RST->RSP_DATA and ALU_FLAGS->RSP_FLAGS; set RSP_VALID=1; go DONE.
    - Same edge: if latched SETF=1 and ALU_OP!=2'b11, NZCV_Q<=ALU_FLAGS. PASS_B never modifies NZCV_Q.
  - Capture occurs at edge k+ALU_LAT (or k+MUL_LAT for MUL).
- DONE:
  - RSP_VALID=1; RSP_DATA/RSP_FLAGS held stable until handshake.
  - REQ_READY=0.
  - On RSP_VALID&RSP_READY: RSP_VALID<=0, go IDLE.
  - REQ_READY returns to 1 the cycle after the handshake.
- RSP_READY is ignored outside DONE. REQ_VALID is ignored while REQ_READY=0; the requester must hold the request stable.
- A carry chain (REQ_USEC=1) uses NZCV_Q as updated by the previous SETF op. Ordering is guaranteed because only one op is in flight.
- Counter width = clog2(max(ALU_LAT,MUL_LAT)+1). No wrap: it is reloaded only at accept.

Optional Feature:
- Macro ALU_SEQ_BACK2BACK_EN.
- Defined:
  - In DONE, REQ_READY = RSP_READY (combinational).
  - A simultaneous response handshake and request accept goes directly DONE->EXEC, loading new operands on that same edge.
  - The ALU_CIN carry source is NZCV_Q as it stands before that edge: the just-completed op's flag update is not visible, so the requester must insert one idle cycle between a SETF op and a dependent USEC op.
  - Sustained throughput is one op per ALU_LAT+1 cycles.
- Undefined: the DONE->IDLE->EXEC path exactly as above; throughput is one op per ALU_LAT+2 cycles.

Test Plan:
- Reset release, then idle -> REQ_READY=1, RSP_VALID=0, NZCV_Q=0, ALU_OP=2'b11.
- ADD A=0x000005, B=0x000003, SETF=1, RSP_READY=1 -> RSP_VALID exactly 1 cycle after accept; RSP_DATA=0x000008; NZCV_Q=0000.
- SUB A=0x000003, B=0x000003, SETF=1, then PASS_B B=0x800000, SETF=1 -> first op Z=1 in NZCV_Q; PASS_B gives RSP_DATA=0x800000, RSP_FLAGS[0]=1, and NZCV_Q unchanged.
- MUL A=0x000010, B=0x000020 with MUL_LAT=3 -> RSP_VALID 3 cycles after accept; RSP_DATA=0x000200; REQ_VALID pulsed during EXEC is not accepted.
- ADD A=0xFFFFFF, B=0x000001, SETF=1 (C=1), then ADD A=0, B=0, USEC=1 -> second op ALU_CIN=1, RSP_DATA=0x000001.
- RSP_READY held 0 for 5 cycles in DONE, then RST_N pulsed low for 1 cycle -> RSP_DATA stable during stall; after reset RSP_VALID=0, NZCV_Q=0, REQ_READY=1.
